l2_home_responder: RTL
======================

# l2_home_responder

Home-node responder for the L2 request channel: accepts coherence requests an L2 issues on its request-out port and returns the matching responses on the L2's response-in port. It backs a small line-addressed store with word-granular ownership tracking, serving as the LLC-side endpoint for unit and subsystem benches and for single-L2 bring-up configurations. Requests are serviced one at a time; forwards are never generated.

## Interface
- MEM_AW, 6: index bits; store holds 2^MEM_AW lines, indexed by `req_addr[MEM_AW-1:0]`
- LINE_ADDR_W, 28: line address width
- WORDS, 4: words per line
- WORD_W, 64: bits per word
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- req_coh_msg  in  3  request type (REQ_V, REQ_S, REQ_WT, REQ_O, REQ_WB, REQ_Odata from spandex_consts.svh)
- req_addr  in  LINE_ADDR_W  line address
- req_line  in  WORDS*WORD_W  write data (REQ_WT, REQ_WB)
- req_word_mask  in  WORDS  words targeted
- rsp_valid  out  1  response present
- rsp_ready  in  1  L2 accepts response
- rsp_coh_msg  out  3  RSP_V, RSP_S, RSP_O, RSP_Odata, RSP_WB_ACK
- rsp_addr  out  LINE_ADDR_W  echo of request address
- rsp_line  out  WORDS*WORD_W  data; unmasked words zero
- rsp_word_mask  out  WORDS  echo of request mask
- rsp_invack_cnt  out  4  always 0
- err_pulse  out  1  one-cycle pulse on unsupported coh_msg
- err_cnt  out  8  saturating count of unsupported requests

## Operation
- States: INIT, IDLE, MEM, RSP.
- INIT: entered on reset; writes zero data and zero owner mask to index 0..2^MEM_AW-1, one per cycle; then IDLE. req_ready low throughout.
- IDLE: req_ready=1. On req_valid&req_ready latch coh_msg, addr, line, word_mask; issue synchronous store read; go MEM. Unsupported coh_msg: no store access, err_pulse=1 next cycle, err_cnt++ (saturate at 255), stay IDLE (request consumed, no response).
- MEM: read data and owner mask available. Perform per-type action, register response, go RSP:
  - REQ_V → RSP_V; REQ_S → RSP_S: rsp_line = stored words under mask; ownership unchanged.
  - REQ_WT → RSP_O: write masked words; ownership unchanged; rsp_line zero.
  - REQ_O → RSP_O: owner |= mask; rsp_line zero.
  - REQ_Odata → RSP_Odata: owner |= mask; rsp_line = stored masked words.
  - REQ_WB → RSP_WB_ACK: write only words in mask & owner; owner &= ~mask; words in mask but not owned are discarded, not written.
- RSP: rsp_valid=1, all rsp_* stable until rsp_ready. On handshake → IDLE.
- Store write (data and owner) occurs at end of the MEM cycle; a following request to the same line observes it.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_* fields 0, err_pulse=0, err_cnt=0.
- INIT lasts exactly 2^MEM_AW cycles after rst deasserts; req_ready first high in cycle 2^MEM_AW.
- Accept at cycle N → MEM at N+1 → rsp_valid at N+2 (2-cycle latency, 0 back-pressure).
- Back-to-back minimum: one request per 3 cycles (accept, MEM, RSP with immediate ready); req_ready rises the cycle after the response handshake.
- req_ready is 0 in MEM and RSP; no combinational path from req_valid to req_ready or from rsp_ready to rsp_valid.
- rst asserted mid-operation (any state): pending request/response dropped, outputs to reset values next cycle, INIT restarts from index 0.
- Address index aliasing: lines differing only above MEM_AW bits share an entry; documented, not detected.

## Test plan
- Reset then idle: rst for 2 cycles, MEM_AW=6 → req_ready low for exactly 64 cycles, then high; rsp_valid stays 0.
- Write-through then read: REQ_WT addr 0x10, mask 0b0101, words 0xA/0xB → RSP_O at N+2; then REQ_V addr 0x10 mask 0b1111 → RSP_V line {0,0xB?…} i.e. word0=0xA, word2=0xB, words1,3=0.
- Ownership: REQ_O addr 0x3 mask 0b0011 → RSP_O invack 0; REQ_WB addr 0x3 mask 0b1111 data all 0x5 → RSP_WB_ACK; REQ_V → words0,1=0x5, words2,3=0; second REQ_WB same data 0x7 → no words change.
- Back-pressure: hold rsp_ready=0 for 10 cycles after RSP_Odata → rsp_* constant, req_ready 0, new req_valid not accepted until cycle after handshake.
- Unsupported coh_msg 3'b111 → err_pulse one cycle, err_cnt=1, no rsp_valid; 300 such requests → err_cnt=255.
- Reset mid-RSP: rst while rsp_valid=1 → rsp_valid 0 next cycle, INIT reruns, prior writes read back as zero.

Source files
------------

// File: rtl/l2_home_responder.sv
// l2_home_responder: LLC-side home node for a single L2. Accepts one coherence
// request at a time, services it against a small line-addressed store with
// per-word ownership bits, and returns one response. No forwards are generated.
// The store is indexed by the low MEM_AW bits of the line address, so lines
// that differ only above those bits alias onto the same entry (not detected).
//
// Message encodings used on req_coh_msg / rsp_coh_msg:
//   requests : REQ_V=0, REQ_S=1, REQ_WT=2, REQ_O=3, REQ_WB=4, REQ_Odata=5
//              (6 and 7 are unsupported and only bump the error counter)
//   responses: RSP_V=0, RSP_S=1, RSP_O=2, RSP_Odata=3, RSP_WB_ACK=4
module l2_home_responder #(
  parameter int MEM_AW      = 6,
  parameter int LINE_ADDR_W = 28,
  parameter int WORDS       = 4,
  parameter int WORD_W      = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [2:0]                req_coh_msg,
  input  logic [LINE_ADDR_W-1:0]    req_addr,
  input  logic [WORDS*WORD_W-1:0]   req_line,
  input  logic [WORDS-1:0]          req_word_mask,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [2:0]                rsp_coh_msg,
  output logic [LINE_ADDR_W-1:0]    rsp_addr,
  output logic [WORDS*WORD_W-1:0]   rsp_line,
  output logic [WORDS-1:0]          rsp_word_mask,
  output logic [3:0]                rsp_invack_cnt,
  output logic                      err_pulse,
  output logic [7:0]                err_cnt
);

  localparam int LINE_W = WORDS * WORD_W;
  localparam int DEPTH  = 1 << MEM_AW;

  localparam logic [2:0] REQ_V      = 3'd0;
  localparam logic [2:0] REQ_S      = 3'd1;
  localparam logic [2:0] REQ_WT     = 3'd2;
  localparam logic [2:0] REQ_O      = 3'd3;
  localparam logic [2:0] REQ_WB     = 3'd4;
  localparam logic [2:0] REQ_ODATA  = 3'd5;

  localparam logic [2:0] RSP_V      = 3'd0;
  localparam logic [2:0] RSP_S      = 3'd1;
  localparam logic [2:0] RSP_O      = 3'd2;
  localparam logic [2:0] RSP_ODATA  = 3'd3;
  localparam logic [2:0] RSP_WB_ACK = 3'd4;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_MEM  = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  // Expand a per-word mask into a per-bit mask over the whole line.
  function automatic logic [LINE_W-1:0] word_bits(input logic [WORDS-1:0] m);
    logic [LINE_W-1:0] b;
    b = '0;
    for (int w = 0; w < WORDS; w++) begin
      b[w*WORD_W +: WORD_W] = {WORD_W{m[w]}};
    end
    return b;
  endfunction

  // True for request types this home node knows how to service.
  function automatic logic is_supported(input logic [2:0] msg);
    logic ok;
    case (msg)
      REQ_V, REQ_S, REQ_WT, REQ_O, REQ_WB, REQ_ODATA: ok = 1'b1;
      default:                                         ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Backing store: line data and per-word ownership.
  logic [LINE_W-1:0]      data_mem  [DEPTH];
  logic [WORDS-1:0]       owner_mem [DEPTH];

  state_t                 state_r, state_n;
  logic [MEM_AW-1:0]      init_idx_r;

  // Latched request and store read data.
  logic [2:0]             msg_r;
  logic [LINE_ADDR_W-1:0] addr_r;
  logic [LINE_W-1:0]      line_r;
  logic [WORDS-1:0]       mask_r;
  logic [LINE_W-1:0]      rd_data_r;
  logic [WORDS-1:0]       rd_owner_r;

  // Registered outputs.
  logic                   req_ready_r;
  logic                   rsp_valid_r;
  logic [2:0]             rsp_msg_r;
  logic [LINE_ADDR_W-1:0] rsp_addr_r;
  logic [LINE_W-1:0]      rsp_line_r;
  logic [WORDS-1:0]       rsp_mask_r;
  logic                   err_pulse_r;
  logic [7:0]             err_cnt_r;

  // Per-request action results and store write port.
  logic [2:0]             act_msg_s;
  logic [LINE_W-1:0]      act_line_s;
  logic                   act_mod_s;
  logic [LINE_W-1:0]      act_data_s;
  logic [WORDS-1:0]       act_owner_s;
  logic                   mem_we_s;
  logic [MEM_AW-1:0]      mem_widx_s;
  logic [LINE_W-1:0]      mem_wdata_s;
  logic [WORDS-1:0]       mem_wowner_s;

  logic                   accept_s;
  logic                   bad_req_s;

  assign accept_s  = req_ready_r & req_valid;
  assign bad_req_s = accept_s & ~is_supported(req_coh_msg);

  // State register and init-sweep index; reset restarts the clearing sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_INIT;
      init_idx_r <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == ST_INIT) begin
        init_idx_r <= init_idx_r + MEM_AW'(1);
      end
    end
  end

  // Next-state logic: unsupported requests are consumed in IDLE without leaving it.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_INIT: begin
        if (init_idx_r == {MEM_AW{1'b1}}) state_n = ST_IDLE;
        else                              state_n = ST_INIT;
      end
      ST_IDLE: begin
        if (accept_s && is_supported(req_coh_msg)) state_n = ST_MEM;
        else                                       state_n = ST_IDLE;
      end
      ST_MEM: state_n = ST_RSP;
      ST_RSP: begin
        if (rsp_ready) state_n = ST_IDLE;
        else           state_n = ST_RSP;
      end
      default: state_n = ST_INIT;
    endcase
  end

  // Per-type action in MEM: response type/data and the updated store entry.
  always_comb begin
    act_msg_s   = RSP_V;
    act_line_s  = '0;
    act_mod_s   = 1'b0;
    act_data_s  = rd_data_r;
    act_owner_s = rd_owner_r;
    case (msg_r)
      REQ_V: begin
        act_msg_s  = RSP_V;
        act_line_s = rd_data_r & word_bits(mask_r);
      end
      REQ_S: begin
        act_msg_s  = RSP_S;
        act_line_s = rd_data_r & word_bits(mask_r);
      end
      REQ_WT: begin
        act_msg_s  = RSP_O;
        act_mod_s  = 1'b1;
        act_data_s = (rd_data_r & ~word_bits(mask_r)) | (line_r & word_bits(mask_r));
      end
      REQ_O: begin
        act_msg_s   = RSP_O;
        act_mod_s   = 1'b1;
        act_owner_s = rd_owner_r | mask_r;
      end
      REQ_ODATA: begin
        act_msg_s   = RSP_ODATA;
        act_line_s  = rd_data_r & word_bits(mask_r);
        act_mod_s   = 1'b1;
        act_owner_s = rd_owner_r | mask_r;
      end
      REQ_WB: begin
        // Only words the L2 actually owns are written back; others are dropped.
        act_msg_s   = RSP_WB_ACK;
        act_mod_s   = 1'b1;
        act_data_s  = (rd_data_r & ~word_bits(mask_r & rd_owner_r))
                    | (line_r & word_bits(mask_r & rd_owner_r));
        act_owner_s = rd_owner_r & ~mask_r;
      end
      default: begin
        act_msg_s = RSP_V;
      end
    endcase
  end

  // Store write-port mux: zero-fill during INIT, action result at end of MEM.
  always_comb begin
    mem_we_s     = 1'b0;
    mem_widx_s   = init_idx_r;
    mem_wdata_s  = '0;
    mem_wowner_s = '0;
    if (rst) begin
      mem_we_s = 1'b0;
    end else if (state_r == ST_INIT) begin
      mem_we_s = 1'b1;
    end else if (state_r == ST_MEM && act_mod_s) begin
      mem_we_s     = 1'b1;
      mem_widx_s   = addr_r[MEM_AW-1:0];
      mem_wdata_s  = act_data_s;
      mem_wowner_s = act_owner_s;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Store write port.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      data_mem[mem_widx_s]  <= mem_wdata_s;
      owner_mem[mem_widx_s] <= mem_wowner_s;
    end
  end

  // Synchronous store read, issued on a supported request acceptance.
  always_ff @(posedge clk) begin
    if (accept_s && is_supported(req_coh_msg)) begin
      rd_data_r  <= data_mem[req_addr[MEM_AW-1:0]];
      rd_owner_r <= owner_mem[req_addr[MEM_AW-1:0]];
    end
  end

  // Request latch, loaded when a request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_r  <= 3'd0;
      addr_r <= '0;
      line_r <= '0;
      mask_r <= '0;
    end else if (accept_s) begin
      msg_r  <= req_coh_msg;
      addr_r <= req_addr;
      line_r <= req_line;
      mask_r <= req_word_mask;
    end
  end

  // Registered handshake, response and error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_msg_r   <= 3'd0;
      rsp_addr_r  <= '0;
      rsp_line_r  <= '0;
      rsp_mask_r  <= '0;
      err_pulse_r <= 1'b0;
      err_cnt_r   <= 8'd0;
    end else begin
      req_ready_r <= (state_n == ST_IDLE);
      rsp_valid_r <= (state_n == ST_RSP);
      err_pulse_r <= bad_req_s;
      if (bad_req_s && err_cnt_r != 8'hFF) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
      if (state_r == ST_MEM) begin
        rsp_msg_r  <= act_msg_s;
        rsp_addr_r <= addr_r;
        rsp_line_r <= act_line_s;
        rsp_mask_r <= mask_r;
      end
    end
  end

  assign req_ready      = req_ready_r;
  assign rsp_valid      = rsp_valid_r;
  assign rsp_coh_msg    = rsp_msg_r;
  assign rsp_addr       = rsp_addr_r;
  assign rsp_line       = rsp_line_r;
  assign rsp_word_mask  = rsp_mask_r;
  assign rsp_invack_cnt = 4'd0;
  assign err_pulse      = err_pulse_r;
  assign err_cnt        = err_cnt_r;

endmodule
